regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, 32, width of write data.
REQ-002 Parameter ADDR_W, 5, width of register address.
REQ-003 Parameter DEPTH, 4, number of long-latency queue entries; power of two and at least 2.
REQ-004 Parameter STARVE_LIM, 8, consecutive blocked cycles before a stall is requested; range 1..255.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pipe_we  in  1  pipeline writeback valid; always accepted, never back-pressured.
REQ-008 pipe_waddr  in  ADDR_W  pipeline destination register.
REQ-009 pipe_wdata  in  DATA_W  pipeline result.
REQ-010 lu_valid  in  1  long-latency unit result valid.
REQ-011 lu_waddr  in  ADDR_W  long-latency destination register.
REQ-012 lu_wdata  in  DATA_W  long-latency result.
REQ-013 lu_ready  out  1  queue can accept; a transfer occurs when lu_valid and lu_ready are both 1.
REQ-014 chk_addr  in  ADDR_W  hazard query address.
REQ-015 chk_pending  out  1  combinational; 1 when any live queue entry targets chk_addr and chk_addr is not 0.
REQ-016 stall_req  out  1  registered request for the pipeline to withhold pipe_we.
REQ-017 we  out  1  registered register-file write enable.
REQ-018 waddr  out  ADDR_W  registered register-file write address.
REQ-019 wdata  out  DATA_W  registered register-file write data.
REQ-020 count  out  log2(DEPTH)+1  number of queue entries, live or dead.

Function
REQ-021 lu_ready SHALL equal (count != DEPTH); it SHALL NOT depend on a same-cycle pop.
REQ-022 An accepted lu transfer with lu_waddr != 0 SHALL be enqueued as a live entry at the tail.
REQ-023 An accepted lu transfer with lu_waddr == 0 SHALL be consumed and discarded: no enqueue, count unchanged.
REQ-024 When pipe_we=1 and pipe_waddr != 0, the arbiter SHALL set we=1, waddr=pipe_waddr and wdata=pipe_wdata on the next edge (1-cycle latency).
REQ-025 A pipe_we with pipe_waddr == 0 SHALL produce we=0 and SHALL NOT pop the queue.
REQ-026 With pipe_we=0 and the queue non-empty, the head entry SHALL be popped.
  - live head: we=1 with the head address and data on the next edge.
  - dead head: we=0; the pop still occurs.
REQ-027 With pipe_we=0 and the queue empty, we SHALL be 0 on the next edge; there is no bypass, so minimum lu-to-we latency is 2 cycles.
REQ-028 The pipeline SHALL have priority over the queue; at most one write per cycle.
REQ-029 WAW kill: a pipe write with pipe_waddr != 0 SHALL mark every live queue entry with the same address dead on that edge.
REQ-030 A simultaneous enqueue with a matching address SHALL NOT be killed; the lu result is younger than the pipe result.
REQ-031 A dead entry SHALL NOT contribute to chk_pending.
REQ-032 An lu transfer accepted in the current cycle SHALL NOT contribute to chk_pending until the following cycle.
REQ-033 A same-cycle push and pop SHALL leave count unchanged.
REQ-034 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-035 Starvation counter: increment when the queue is non-empty and pipe_we=1; clear on any cycle the queue is popped or is empty; saturate at STARVE_LIM.
REQ-036 stall_req SHALL be 1 while the starvation counter equals STARVE_LIM, and SHALL clear on the edge after a pop.
REQ-037 If pipe_we=1 while stall_req=1, the pipe write SHALL still take priority and the stall SHALL persist.

Reset
REQ-038 While rst=1 at an edge, the block SHALL clear: we=0, waddr=0, wdata=0, stall_req=0, count=0, pointers=0, all entries dead, starvation counter=0.
REQ-039 Reset mid-operation SHALL discard all queued entries without writing them.
REQ-040 lu_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-041 Pipe only: pipe_we=1, pipe_waddr=3, pipe_wdata=0x11 -> next cycle we=1, waddr=3, wdata=0x11; count stays 0.
REQ-042 LU drain: lu write (7, 0xAB) with pipe idle -> chk_addr=7 gives chk_pending=1 the next cycle; we=1, waddr=7 two cycles after the transfer; count returns to 0.
REQ-043 Full: 4 lu transfers while pipe_we=1 -> count=4 and lu_ready=0; drop pipe_we -> writes retire in FIFO order, one per cycle, and lu_ready rises after the first pop.
REQ-044 WAW kill: queue holds (5, 0x1); pipe writes (5, 0x2) -> chk_pending(5)=0; the head pops with we=0; the register-file write sequence is 0x2 only.
REQ-045 Starvation: queue non-empty, pipe_we=1 for 8 consecutive cycles -> stall_req=1; drop pipe_we -> head written, stall_req=0 the following cycle.
REQ-046 Reset: 3 entries queued, rst pulsed for 1 cycle -> count=0, we=0, lu_ready=1; no queued entry is ever written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. Pipeline results win every cycle; long-latency results wait in a small FIFO.
// Pipe writes kill queued entries with the same address, and starvation of the queue raises stall_req.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [ADDR_W-1:0]          pipe_waddr,
    input  logic [DATA_W-1:0]          pipe_wdata,
    input  logic                       lu_valid,
    input  logic [ADDR_W-1:0]          lu_waddr,
    input  logic [DATA_W-1:0]          lu_wdata,
    output logic                       lu_ready,
    input  logic [ADDR_W-1:0]          chk_addr,
    output logic                       chk_pending,
    output logic                       stall_req,
    output logic                       we,
    output logic [ADDR_W-1:0]          waddr,
    output logic [DATA_W-1:0]          wdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_live;
    logic [DEPTH-1:0]  live_next;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [STV_W-1:0]  starve_cnt;
    logic [STV_W-1:0]  starve_next;

    logic lu_fire;
    logic push;
    logic pop;
    logic pipe_wr;
    logic pend_hit;

    always_comb begin
        lu_ready = (count != FULL_CNT);
        lu_fire  = lu_valid & lu_ready;
        // Address-0 results are architecturally void: accept the handshake but drop them.
        push     = lu_fire & (lu_waddr != '0);
        pipe_wr  = pipe_we & (pipe_waddr != '0);
        pop      = ~pipe_we & (count != '0);
    end

    always_comb begin
        live_next = q_live;
        if (pipe_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_addr[i] == pipe_waddr) begin
                    live_next[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_next[head] = 1'b0;
        end
        // Applied after the kill so a same-cycle younger lu result survives.
        if (push) begin
            live_next[tail] = 1'b1;
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i] && (q_addr[i] == chk_addr)) begin
                pend_hit = 1'b1;
            end
        end
        chk_pending = pend_hit & (chk_addr != '0);
    end

    always_comb begin
        starve_next = starve_cnt;
        if ((count == '0) || pop) begin
            starve_next = '0;
        end else if (pipe_we && (starve_cnt != STV_MAX)) begin
            starve_next = starve_cnt + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            stall_req  <= 1'b0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            q_live     <= '0;
            starve_cnt <= '0;
        end else begin
            if (pipe_wr) begin
                we    <= 1'b1;
                waddr <= pipe_waddr;
                wdata <= pipe_wdata;
            end else if (pop && q_live[head]) begin
                we    <= 1'b1;
                waddr <= q_addr[head];
                wdata <= q_data[head];
            end else begin
                we    <= 1'b0;
            end

            q_live <= live_next;

            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            starve_cnt <= starve_next;
            stall_req  <= (starve_next == STV_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= lu_waddr;
            q_data[tail] <= lu_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int LIM    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic              lu_ready;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_pending;
    logic              stall_req;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .chk_addr(chk_addr), .chk_pending(chk_pending),
        .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata), .count(count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                live;
    } ent_t;

    ent_t              mq[$];
    int                m_starve;
    logic              e_we;
    logic [ADDR_W-1:0] e_waddr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_stall;
    logic              e_pend;
    logic              e_ready;
    logic              s_pend;
    logic              s_ready;
    int                n_checks = 0;
    int                n_fail   = 0;

    function automatic bit model_pend(input logic [ADDR_W-1:0] a);
        if (a == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
        chk_addr = 0;
    endtask

    // Snapshot combinational outputs, advance the model by the rules of the block, then clock the DUT.
    task automatic tick();
        bit   pw, popd, pre_empty;
        ent_t h;
        #1;
        s_pend  = chk_pending;
        s_ready = lu_ready;
        e_pend  = model_pend(chk_addr);
        e_ready = (mq.size() != DEPTH);
        if (rst) begin
            mq.delete();
            m_starve = 0;
            e_we = 0; e_waddr = 0; e_wdata = 0; e_stall = 0;
        end else begin
            pre_empty = (mq.size() == 0);
            pw   = pipe_we && (pipe_waddr != 0);
            popd = 0;
            if (pw) begin
                e_we = 1; e_waddr = pipe_waddr; e_wdata = pipe_wdata;
                foreach (mq[i]) if (mq[i].addr == pipe_waddr) mq[i].live = 0;
            end else if (!pipe_we && !pre_empty) begin
                h = mq.pop_front();
                popd = 1;
                e_we = h.live;
                if (h.live) begin
                    e_waddr = h.addr; e_wdata = h.data;
                end
            end else begin
                e_we = 0;
            end
            if (pre_empty || popd) m_starve = 0;
            else if (pipe_we && m_starve < LIM) m_starve++;
            if (lu_valid && e_ready && lu_waddr != 0) begin
                h.addr = lu_waddr; h.data = lu_wdata; h.live = 1;
                mq.push_back(h);
            end
            e_stall = (m_starve == LIM);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we actual=%b required=0", we); end
        n_checks++; if (waddr !== '0) begin n_fail++; $display("FAIL reset_waddr actual=%0d required=0", waddr); end
        n_checks++; if (wdata !== '0) begin n_fail++; $display("FAIL reset_wdata actual=%h required=0", wdata); end
        n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall actual=%b required=0", stall_req); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count actual=%0d required=0", count); end
        rst = 0;
        #1;
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lu_ready actual=%b required=1", lu_ready); end
    endtask

    task automatic test_pipe_only();
        idle();
        pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h11;
        tick();
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h11}) begin
            n_fail++; $display("FAIL pipe_write actual=%b/%0d/%h required=1/3/11", we, waddr, wdata); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL pipe_count actual=%0d required=0", count); end
        pipe_waddr = 0; pipe_wdata = 32'h22;
        tick();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL pipe_zero_addr actual=%b required=0", we); end
        idle();
        tick();
    endtask

    task automatic test_lu_drain();
        idle();
        lu_valid = 1; lu_waddr = 7; lu_wdata = 32'hAB;
        tick();
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL drain_count1 actual=%0d required=1", count); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL drain_no_bypass actual=%b required=0", we); end
        idle();
        chk_addr = 7;
        tick();
        n_checks++; if (s_pend !== 1'b1) begin n_fail++; $display("FAIL drain_pending actual=%b required=1", s_pend); end
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd7, 32'hAB}) begin
            n_fail++; $display("FAIL drain_write actual=%b/%0d/%h required=1/7/ab", we, waddr, wdata); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count0 actual=%0d required=0", count); end
    endtask

    task automatic test_full();
        idle();
        pipe_we = 1; pipe_waddr = 1; pipe_wdata = 32'h100;
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1; lu_waddr = 5'(8 + i); lu_wdata = 32'(32'hF0 + i);
            tick();
        end
        lu_valid = 0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count actual=%0d required=4", count); end
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready actual=%b required=0", lu_ready); end
        pipe_we = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'(8 + i), 32'(32'hF0 + i)}) begin
                n_fail++; $display("FAIL full_order%0d actual=%b/%0d/%h required=1/%0d/%h", i, we, waddr, wdata, 8 + i, 32'hF0 + i); end
            if (i == 0) begin
                n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise actual=%b required=1", lu_ready); end
            end
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_empty actual=%0d required=0", count); end
    endtask

    task automatic test_waw_kill();
        idle();
        pipe_we = 1; pipe_waddr = 9; pipe_wdata = 32'h9;
        lu_valid = 1; lu_waddr = 5; lu_wdata = 32'h1;
        tick();
        lu_valid = 0;
        pipe_waddr = 5; pipe_wdata = 32'h2; chk_addr = 5;
        tick();
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'h2}) begin
            n_fail++; $display("FAIL waw_pipe actual=%b/%0d/%h required=1/5/2", we, waddr, wdata); end
        pipe_we = 0;
        tick();
        n_checks++; if (s_pend !== 1'b0) begin n_fail++; $display("FAIL waw_pending actual=%b required=0", s_pend); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL waw_dead_pop actual=%b required=0", we); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL waw_count actual=%0d required=0", count); end
    endtask

    task automatic test_starve();
        idle();
        pipe_we = 1; pipe_waddr = 2; pipe_wdata = 32'h2;
        lu_valid = 1; lu_waddr = 12; lu_wdata = 32'hC;
        tick();
        lu_valid = 0;
        for (int i = 1; i <= LIM; i++) begin
            tick();
            if (i == LIM - 1) begin
                n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_early actual=%b required=0", stall_req); end
            end
        end
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_set actual=%b required=1", stall_req); end
        tick();
        n_checks++; if ({stall_req, we, waddr} !== {1'b1, 1'b1, 5'd2}) begin
            n_fail++; $display("FAIL starve_persist actual=%b/%b/%0d required=1/1/2", stall_req, we, waddr); end
        pipe_we = 0;
        tick();
        n_checks++; if ({stall_req, we, waddr, wdata} !== {1'b0, 1'b1, 5'd12, 32'hC}) begin
            n_fail++; $display("FAIL starve_release actual=%b/%b/%0d/%h required=0/1/12/c", stall_req, we, waddr, wdata); end
    endtask

    task automatic test_reset_mid();
        idle();
        pipe_we = 1; pipe_waddr = 1; pipe_wdata = 32'h1;
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1; lu_waddr = 5'(20 + i); lu_wdata = 32'(32'h50 + i);
            tick();
        end
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_checks++; if ({count, we, lu_ready} !== {3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid actual=%0d/%b/%b required=0/0/1", count, we, lu_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_nowrite%0d actual=%b required=0", i, we); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            pipe_we    = ($urandom_range(0, 99) < 55);
            pipe_waddr = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            lu_valid   = ($urandom_range(0, 99) < 60);
            lu_waddr   = 5'($urandom_range(0, 7));
            lu_wdata   = $urandom;
            chk_addr   = 5'($urandom_range(0, 7));
            rst        = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++; if (s_pend !== e_pend) begin n_fail++; $display("FAIL rnd_pending cyc=%0d actual=%b required=%b", c, s_pend, e_pend); end
            n_checks++; if (s_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d actual=%b required=%b", c, s_ready, e_ready); end
            n_checks++; if ({we, waddr, wdata} !== {e_we, e_waddr, e_wdata}) begin
                n_fail++; $display("FAIL rnd_write cyc=%0d actual=%b/%0d/%h required=%b/%0d/%h", c, we, waddr, wdata, e_we, e_waddr, e_wdata); end
            n_checks++; if (int'(count) != mq.size()) begin n_fail++; $display("FAIL rnd_count cyc=%0d actual=%0d required=%0d", c, count, mq.size()); end
            n_checks++; if (stall_req !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc=%0d actual=%b required=%b", c, stall_req, e_stall); end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_pipe_only();
        test_lu_drain();
        test_full();
        test_waw_kill();
        test_starve();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
